// File: rtl/sar_readout_if.sv
// Output stream of sar_readout: FIFO head word with a valid/ready handshake.
interface sar_readout_if #(
   parameter int WIDTH = 10
);
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/sar_readout.sv
// SAR ADC readout: synchronizes the conversion-complete event, optionally sums
// 2^AVG_LOG2 samples, and queues results in a first-word-fall-through FIFO.
module sar_readout #(
   parameter int ADC_BITS   = 8,
   parameter int AVG_LOG2   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clr,
   input  logic                        compl,
   input  logic [0:ADC_BITS-1]         adc_data,
   sar_readout_if.master               out_if,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output logic                        overflow
);
   localparam int OUT_BITS = ADC_BITS + AVG_LOG2;
   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam int CNT_BITS = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'((1 << AVG_LOG2) - 1);
   localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
   localparam logic [PTR_BITS:0]   PTR_ONE  = (PTR_BITS + 1)'(1);

   logic                s1, s2, s3;
   logic                capture;
   logic [ADC_BITS-1:0] sample;
   logic [OUT_BITS-1:0] acc;
   logic [OUT_BITS-1:0] sum;
   logic [CNT_BITS-1:0] cnt;
   logic [PTR_BITS:0]   wr_ptr, rd_ptr;
   logic [OUT_BITS-1:0] mem [FIFO_DEPTH];
   logic                empty, full;
   logic                push_req, push, pop;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= compl;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Falling edge of the synchronized completion flag.
   assign capture = s3 & ~s2;

   // Packed assignment maps leftmost to leftmost, so adc_data[0] (MSB) lands
   // in sample[ADC_BITS-1]: exactly the LSB-first remap.
   assign sample = adc_data;
   assign sum    = (cnt == '0) ? OUT_BITS'(sample) : acc + OUT_BITS'(sample);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
         cnt <= '0;
      end else if (clr) begin
         acc <= '0;
         cnt <= '0;
      end else if (!en) begin
         cnt <= '0;
      end else if (capture) begin
         acc <= sum;
         cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_ONE;
      end
   end

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_BITS] != rd_ptr[PTR_BITS]) &&
                     (wr_ptr[PTR_BITS-1:0] == rd_ptr[PTR_BITS-1:0]);
   assign pop      = ~empty & out_if.out_ready & ~clr;
   assign push_req = capture & en & (cnt == CNT_LAST) & ~clr;
   // When full, a same-cycle pop frees exactly the slot being written.
   assign push     = push_req & (~full | pop);

   // NOTE: the FIFO memory is reset too, so out_data reads 0 straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (clr) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr[PTR_BITS-1:0]] <= sum;
            wr_ptr                    <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         if (push_req && !push) overflow <= 1'b1;
      end
   end

   assign out_if.out_data  = mem[rd_ptr[PTR_BITS-1:0]];
   assign out_if.out_valid = ~empty;
   assign level            = wr_ptr - rd_ptr;
endmodule

// File: tb/tb_sar_readout.sv
// Bench for sar_readout: a bypass instance (AVG_LOG2=0) and an averaging
// instance (AVG_LOG2=2) checked against a queue-level model of the readout.
module tb_sar_readout;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       compl_b = 1'b1, compl_a = 1'b1;
   logic       en_b = 1'b1, en_a = 1'b1;
   logic       clr_b = 1'b0, clr_a = 1'b0;
   logic [0:7] adc_data = '0;
   logic [2:0] level_b, level_a;
   logic       ovf_b, ovf_a;

   int checks = 0;
   int passed = 0;

   sar_readout_if #(.WIDTH(8))  if_b ();
   sar_readout_if #(.WIDTH(10)) if_a ();

   sar_readout #(.ADC_BITS(8), .AVG_LOG2(0), .FIFO_DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .compl(compl_b),
      .adc_data(adc_data), .out_if(if_b), .level(level_b), .overflow(ovf_b)
   );

   sar_readout #(.ADC_BITS(8), .AVG_LOG2(2), .FIFO_DEPTH(4)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .compl(compl_a),
      .adc_data(adc_data), .out_if(if_a), .level(level_a), .overflow(ovf_a)
   );

   always #5 clk = ~clk;

   // Reference model: index 0 = bypass instance, 1 = averaging instance.
   int unsigned mq [2][4];
   int          mn [2];
   bit          movf [2];
   int unsigned psum;
   int          pn;

   function automatic int unsigned to_sample(input logic [0:7] raw);
      logic [7:0] s;
      for (int k = 0; k < 8; k++) s[7-k] = raw[k];
      return 32'(s);
   endfunction

   function automatic void model_push(input int d, input int unsigned w);
      if (mn[d] < 4) begin
         mq[d][mn[d]] = w;
         mn[d]++;
      end else begin
         movf[d] = 1'b1;
      end
   endfunction

   function automatic void model_pop(input int d);
      for (int i = 0; i < 3; i++) mq[d][i] = mq[d][i+1];
      if (mn[d] > 0) mn[d]--;
   endfunction

   function automatic void model_capture(input int d, input logic [7:0] raw);
      if (d == 0) begin
         model_push(0, to_sample(raw));
      end else begin
         psum += to_sample(raw);
         pn++;
         if (pn == 4) begin
            model_push(1, psum);
            psum = 0;
            pn   = 0;
         end
      end
   endfunction

   function automatic void model_reset(input int d);
      mn[d]   = 0;
      movf[d] = 1'b0;
      if (d == 1) begin
         psum = 0;
         pn   = 0;
      end
   endfunction

   function automatic logic [31:0] dut_data(input int d);
      return (d == 0) ? 32'(if_b.out_data) : 32'(if_a.out_data);
   endfunction

   function automatic logic dut_valid(input int d);
      return (d == 0) ? if_b.out_valid : if_a.out_valid;
   endfunction

   function automatic logic [31:0] dut_level(input int d);
      return (d == 0) ? 32'(level_b) : 32'(level_a);
   endfunction

   function automatic logic dut_ovf(input int d);
      return (d == 0) ? ovf_b : ovf_a;
   endfunction

   task automatic set_compl(input int d, input logic v);
      if (d == 0) compl_b = v; else compl_a = v;
   endtask

   task automatic set_ready(input int d, input logic v);
      if (d == 0) if_b.out_ready = v; else if_a.out_ready = v;
   endtask

   // One full upstream conversion: data changes as compl falls, low 4 clk, high 3 clk.
   task automatic convert(input int d, input logic [7:0] raw);
      @(negedge clk);
      adc_data = raw;
      set_compl(d, 1'b0);
      repeat (4) @(negedge clk);
      set_compl(d, 1'b1);
      repeat (3) @(negedge clk);
      if ((d == 0) ? en_b : en_a) model_capture(d, raw);
   endtask

   task automatic drain_and_compare(input int d, input string name);
      while (mn[d] > 0) begin
         checks++;
         if (dut_valid(d) !== 1'b1 || dut_data(d) !== mq[d][0])
            $display("FAIL %s_word: valid=%b data=%0d, required valid=1 data=%0d",
                     name, dut_valid(d), dut_data(d), mq[d][0]);
         else passed++;
         set_ready(d, 1'b1);
         @(negedge clk);
         set_ready(d, 1'b0);
         model_pop(d);
      end
      checks++;
      if (dut_valid(d) !== 1'b0)
         $display("FAIL %s_empty: valid=%b, required 0", name, dut_valid(d));
      else passed++;
   endtask

   task automatic check_idle_outputs(input string name);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dut_valid(d) !== 1'b0 || dut_level(d) !== 0 || dut_ovf(d) !== 1'b0 || dut_data(d) !== 0)
            $display("FAIL %s_%0d: valid=%b level=%0d ovf=%b data=%0d, required all 0",
                     name, d, dut_valid(d), dut_level(d), dut_ovf(d), dut_data(d));
         else passed++;
      end
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      @(negedge clk);
   endtask

   task automatic test_bypass();
      logic [7:0] raw;
      if_b.out_ready = 1'b1;
      for (int n = 0; n < 4; n++) begin
         raw = (n == 0) ? 8'b1000_0001 : 8'($urandom);
         @(negedge clk);
         adc_data = raw;
         compl_b  = 1'b0;
         for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            checks++;
            if (e == 2) begin
               if (if_b.out_valid !== 1'b1 || 32'(if_b.out_data) !== to_sample(raw))
                  $display("FAIL bypass_edge2: valid=%b data=%0h, required valid=1 data=%0h",
                           if_b.out_valid, if_b.out_data, to_sample(raw));
               else passed++;
            end else begin
               if (if_b.out_valid !== 1'b0)
                  $display("FAIL bypass_edge%0d: valid=%b, required 0", e, if_b.out_valid);
               else passed++;
            end
         end
         compl_b = 1'b1;
         repeat (3) @(negedge clk);
      end
      if_b.out_ready = 1'b0;
   endtask

   task automatic test_average();
      int unsigned fixed [4] = '{10, 20, 30, 40};
      for (int n = 0; n < 4; n++) begin
         convert(1, 8'(fixed[n]));
         checks++;
         if (n < 3 && if_a.out_valid !== 1'b0)
            $display("FAIL avg_partial%0d: valid=%b, required 0", n, if_a.out_valid);
         else if (n == 3 && (level_a !== 3'd1 || 32'(if_a.out_data) !== 32'd100))
            $display("FAIL avg_sum: level=%0d data=%0d, required level=1 data=100",
                     level_a, if_a.out_data);
         else passed++;
      end
      drain_and_compare(1, "avg_fixed");
      for (int n = 0; n < 8; n++) convert(1, 8'($urandom));
      checks++;
      if (dut_level(1) !== 32'(mn[1]))
         $display("FAIL avg_rand_level: got %0d, required %0d", dut_level(1), mn[1]);
      else passed++;
      drain_and_compare(1, "avg_rand");
   endtask

   task automatic test_overflow();
      for (int n = 0; n < 6; n++) convert(0, 8'($urandom));
      checks++;
      if (level_b !== 3'(mn[0]) || ovf_b !== movf[0])
         $display("FAIL ovf_state: level=%0d ovf=%b, required level=%0d ovf=%b",
                  level_b, ovf_b, mn[0], movf[0]);
      else passed++;
      drain_and_compare(0, "ovf_drain");
      checks++;
      if (ovf_b !== 1'b1)
         $display("FAIL ovf_sticky: got %b, required 1", ovf_b);
      else passed++;
   endtask

   task automatic test_clear();
      for (int n = 0; n < 3; n++) convert(0, 8'($urandom));
      checks++;
      if (level_b !== 3'(mn[0]))
         $display("FAIL clr_pre_level: got %0d, required %0d", level_b, mn[0]);
      else passed++;
      @(negedge clk);
      clr_b = 1'b1;
      @(negedge clk);
      clr_b = 1'b0;
      model_reset(0);
      checks++;
      if (level_b !== 3'd0 || if_b.out_valid !== 1'b0 || ovf_b !== 1'b0)
         $display("FAIL clr_state: level=%0d valid=%b ovf=%b, required all 0",
                  level_b, if_b.out_valid, ovf_b);
      else passed++;
      // A partial average is discarded by clr as well.
      for (int n = 0; n < 2; n++) convert(1, 8'($urandom));
      @(negedge clk);
      clr_a = 1'b1;
      @(negedge clk);
      clr_a = 1'b0;
      model_reset(1);
      for (int n = 0; n < 4; n++) convert(1, 8'($urandom));
      drain_and_compare(1, "clr_avg");
   endtask

   task automatic test_push_pop_full();
      logic [7:0] raw;
      for (int n = 0; n < 4; n++) convert(0, 8'($urandom));
      raw = 8'($urandom);
      @(negedge clk);
      adc_data = raw;
      compl_b  = 1'b0;
      repeat (2) @(negedge clk);
      if_b.out_ready = 1'b1;
      @(negedge clk);
      if_b.out_ready = 1'b0;
      model_pop(0);
      model_capture(0, raw);
      checks++;
      if (level_b !== 3'(mn[0]) || ovf_b !== movf[0])
         $display("FAIL full_pushpop: level=%0d ovf=%b, required level=%0d ovf=%b",
                  level_b, ovf_b, mn[0], movf[0]);
      else passed++;
      repeat (2) @(negedge clk);
      compl_b = 1'b1;
      repeat (3) @(negedge clk);
      drain_and_compare(0, "full_pushpop");
   endtask

   task automatic test_enable();
      for (int n = 0; n < 2; n++) convert(1, 8'($urandom));
      @(negedge clk);
      en_a = 1'b0;
      psum = 0;
      pn   = 0;
      convert(1, 8'($urandom));
      @(negedge clk);
      en_a = 1'b1;
      checks++;
      if (level_a !== 3'd0)
         $display("FAIL en_discard: level=%0d, required 0", level_a);
      else passed++;
      for (int n = 0; n < 4; n++) convert(1, 8'($urandom));
      checks++;
      if (level_a !== 3'(mn[1]))
         $display("FAIL en_level: got %0d, required %0d", level_a, mn[1]);
      else passed++;
      drain_and_compare(1, "en_sum");
   endtask

   task automatic test_reset_mid();
      for (int n = 0; n < 2; n++) convert(0, 8'($urandom));
      for (int n = 0; n < 2; n++) convert(1, 8'($urandom));
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge clk);
      rst = 1'b1;
      model_reset(0);
      model_reset(1);
      convert(0, 8'($urandom));
      checks++;
      if (level_b !== 3'(mn[0]))
         $display("FAIL rst_mid_level: got %0d, required %0d", level_b, mn[0]);
      else passed++;
      drain_and_compare(0, "rst_mid_word");
   endtask

   initial begin
      if_b.out_ready = 1'b0;
      if_a.out_ready = 1'b0;
      test_reset();
      test_bypass();
      test_average();
      test_overflow();
      test_clear();
      test_push_pop_full();
      test_enable();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
